// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// unbuffered ALU writeback (priority) and load returns queued in a FIFO.
// Exports a per-register busy vector for decode stalls.
// Optional macro STARVE_GUARD_EN: starvation counter that periodically forces
// one FIFO pop (FORCE_LSU state); otherwise strict ALU priority.
module regfile_wb_arbiter #(
    parameter int unsigned LQ_DEPTH   = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [4:0]                  alu_rd,
    input  logic [31:0]                 alu_wd,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [4:0]                  lsu_rd,
    input  logic [31:0]                 lsu_wd,
    output logic [4:0]                  A3,
    output logic [31:0]                 WD3,
    output logic                        EN,
    output logic [31:0]                 busy,
    output logic [$clog2(LQ_DEPTH):0]   lq_count
);

    localparam int unsigned AW = $clog2(LQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = LQ_DEPTH[AW:0];

    typedef enum logic {NORMAL, FORCE_LSU} state_t;
    state_t state;

    logic [4:0]          q_rd [LQ_DEPTH];
    logic [31:0]         q_wd [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] q_vld;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                alu_win;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign lq_count  = count;
    assign alu_ready = (state == NORMAL);
    assign lsu_ready = !full;
    assign alu_win   = alu_valid && alu_ready;
    assign pop       = !alu_win && !empty;
    // rd==0 loads are acknowledged but never stored: they would write nothing.
    assign push      = lsu_valid && !full && (lsu_rd != '0);

    // FIFO payload storage (no reset needed; guarded by q_vld)
    always_ff @(posedge CLK) begin
        if (push) begin
            q_rd[wr_ptr] <= lsu_rd;
            q_wd[wr_ptr] <= lsu_wd;
        end
    end

    // FIFO pointers, occupancy and per-slot valid bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                q_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                q_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: ALU winner, else FIFO head, else idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            A3  <= '0;
            WD3 <= '0;
            EN  <= 1'b0;
        end else if (alu_win) begin
            A3  <= alu_rd;
            WD3 <= alu_wd;
            EN  <= (alu_rd != '0);
        end else if (pop) begin
            A3  <= q_rd[rd_ptr];
            WD3 <= q_wd[rd_ptr];
            EN  <= (q_rd[rd_ptr] != '0);
        end else begin
            EN  <= 1'b0;
        end
    end

    // Busy vector: pending FIFO entries plus the write in the output stage
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            if (q_vld[i]) begin
                busy[q_rd[i]] = 1'b1;
            end
        end
        if (EN) begin
            busy[A3] = 1'b1;
        end
        busy[0] = 1'b0;
    end

`ifdef STARVE_GUARD_EN
    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = STARVE_MAX[CW-1:0];

    state_t        state_next;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_next;

    // State and starvation counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Count ALU grants that block a non-empty FIFO; force one pop at the limit
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            NORMAL: begin
                if (alu_win && !empty) begin
                    starve_cnt_next = starve_cnt + 1'b1;
                end else begin
                    starve_cnt_next = '0;
                end
                if (starve_cnt_next == STARVE_LIM) begin
                    state_next = FORCE_LSU;
                end
            end
            FORCE_LSU: begin
                starve_cnt_next = '0;
                state_next      = NORMAL;
            end
            default: begin
                starve_cnt_next = '0;
                state_next      = NORMAL;
            end
        endcase
    end
`else
    assign state = NORMAL;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed steps plus a short
// random phase; expected writes are queued when driven and compared when the
// registered write port produces them.
module tb_regfile_wb_arbiter;

    localparam int unsigned LQ_DEPTH   = 4;
    localparam int unsigned STARVE_MAX = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_wd = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_wd = '0;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        EN;
    logic [31:0] busy;
    logic [2:0]  lq_count;

    regfile_wb_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .A3(A3), .WD3(WD3), .EN(EN), .busy(busy), .lq_count(lq_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    wr_t mq[$];   // model of the load FIFO
    wr_t sb[$];   // scoreboard of expected write-port contents
    int  total = 0;
    int  bad = 0;
    int  m_state = 0;
    int  m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy(input wr_t o);
        logic [31:0] b;
        b = '0;
        foreach (mq[i]) b[mq[i].rd] = 1'b1;
        if (o.en) b[o.rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic do_reset();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mq.delete();
        sb.delete();
        m_state = 0;
        m_cnt = 0;
        check("rst_EN", 32'(EN), 32'(0));
        check("rst_A3", 32'(A3), 32'(0));
        check("rst_WD3", WD3, 32'(0));
        check("rst_busy", busy, 32'(0));
        check("rst_lq_count", 32'(lq_count), 32'(0));
    endtask

    // One cycle: drive inputs, predict, clock, compare the popped expectation.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
        wr_t  e;
        wr_t  o;
        logic rdy;
        logic full_b;
        logic nonempty_b;
        alu_valid = av; alu_rd = ard; alu_wd = awd;
        lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
        #1;
        rdy        = (m_state == 0);
        full_b     = (mq.size() == LQ_DEPTH);
        nonempty_b = (mq.size() != 0);
        check("alu_ready", 32'(alu_ready), 32'(rdy));
        check("lsu_ready", 32'(lsu_ready), 32'(!full_b));
        e = '0;
        if (av && rdy) begin
            e.en = (ard != 5'd0);
            e.rd = ard;
            e.wd = awd;
        end else if (nonempty_b) begin
            e = mq.pop_front();
        end
        if (lv && !full_b && lrd != 5'd0) mq.push_back({1'b1, lrd, lwd});
`ifdef STARVE_GUARD_EN
        if (m_state != 0) begin
            m_cnt = 0;
            m_state = 0;
        end else begin
            if (av && rdy && nonempty_b) m_cnt++;
            else m_cnt = 0;
            if (m_cnt == STARVE_MAX) m_state = 1;
        end
`endif
        sb.push_back(e);
        @(posedge CLK);
        #1;
        o = sb.pop_front();
        check("EN", 32'(EN), 32'(o.en));
        if (o.en) begin
            check("A3", 32'(A3), 32'(o.rd));
            check("WD3", WD3, o.wd);
        end
        check("lq_count", 32'(lq_count), 32'(mq.size()));
        check("busy", busy, model_busy(o));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        do_reset();
        idle(1);

        // single ALU write, busy[5] for exactly one cycle
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("busy5_set", 32'(busy[5]), 32'(1));
        idle(1);
        check("busy5_clr", 32'(busy[5]), 32'(0));

        // rd==0 from both sources: consumed, nothing written or queued
        step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
        check("rd0_lq_count", 32'(lq_count), 32'(0));
        idle(1);

        // back-to-back loads with idle ALU, in-order drain
        for (int i = 7; i <= 10; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
        idle(3);

        // ALU continuously valid while loads fill the FIFO past full
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'(1 + i), 32'hA000 + 32'(i), 1'b1, 5'(20 + i), 32'hB000 + 32'(i));
        // full FIFO, ALU idle: push refused while a pop happens
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'hC0C0);
        idle(6);

        // one queued load behind a continuously valid ALU
        step(1'b1, 5'd2, 32'h2000, 1'b1, 5'd12, 32'h1212);
        for (int i = 0; i < 7; i++)
            step(1'b1, 5'(3 + i), 32'h3000 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(3);

        // reset with two queued loads: nothing written afterwards
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd14, 32'h1414);
        step(1'b1, 5'd1, 32'h12, 1'b1, 5'd15, 32'h1515);
        check("pre_rst_lq_count", 32'(lq_count), 32'(2));
        do_reset();
        idle(4);

        // random mixed traffic
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
